// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide: 33-cycle latency (accept, 32 iterations, DONE); fast path for div-by-zero/overflow.
// Backpressure: stall_o holds the front of the pipeline from the accept cycle through the last iteration.
module rv32m_muldiv_unit #(
    parameter int XLEN         = 32,
    parameter int FAST_SPECIAL = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            kill_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [2:0]  op_q;
    logic [63:0] acc, acc_nxt;
    logic [31:0] opb;
    logic        neg_res, neg_rem;

    logic        accept, sgn1, sgn2, neg1, neg2, div_zero, div_ovf, special;
    logic [31:0] mag1, mag2, special_res, final_res;
    logic [32:0] sum, rshift;
    logic [31:0] sub;
    logic        ge;
    logic [63:0] prod;
    logic [31:0] quo, rem;

    assign accept = start_i && !kill_i;

    always_comb begin
        sgn1        = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
        sgn2        = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
        neg1        = sgn1 && rs1_i[31];
        neg2        = sgn2 && rs2_i[31];
        mag1        = neg1 ? -rs1_i : rs1_i;
        mag2        = neg2 ? -rs2_i : rs2_i;
        div_zero    = (rs2_i == 32'd0);
        div_ovf     = (op_i == 3'd4 || op_i == 3'd6) && rs1_i == 32'h8000_0000 && rs2_i == 32'hFFFF_FFFF;
        special     = (FAST_SPECIAL != 0) && op_i[2] && (div_zero || div_ovf);
        special_res = op_i[1] ? (div_zero ? rs1_i : 32'd0) : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);
    end

    // acc holds {hi, lo}: MUL keeps the multiplier in lo and shifts right; DIV keeps {remainder, dividend/quotient} and shifts left.
    always_comb begin
        sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
        rshift  = {acc[63:32], acc[31]};
        ge      = rshift >= {1'b0, opb};
        sub     = rshift[31:0] - opb;
        acc_nxt = acc;
        if (op_q[2])
            acc_nxt = ge ? {sub, acc[30:0], 1'b1} : {rshift[31:0], acc[30:0], 1'b0};
        else
            acc_nxt = {sum, acc[31:1]};
        prod      = neg_res ? -acc_nxt : acc_nxt;
        quo       = neg_res ? -acc_nxt[31:0] : acc_nxt[31:0];
        rem       = neg_rem ? -acc_nxt[63:32] : acc_nxt[63:32];
        final_res = op_q[2] ? (op_q[1] ? rem : quo) : ((op_q == 3'd0) ? prod[31:0] : prod[63:32]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : (op_i[2] ? DIV : MUL);
            MUL, DIV: begin
                if (kill_i)
                    state_nxt = IDLE;
                else if (cnt == 5'd31)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state == MUL) || (state == DIV);
        done_o  = (state == DONE);
        stall_o = !rst_i && (((state == IDLE) && accept) || busy_o);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt      <= 5'd0;
            op_q     <= 3'd0;
            acc      <= 64'd0;
            opb      <= 32'd0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op_i;
                        acc     <= {32'd0, mag1};
                        opb     <= mag2;
                        cnt     <= 5'd0;
                        // A zero divisor yields all-ones quotient regardless of the dividend sign.
                        neg_res <= (neg1 ^ neg2) && !(op_i[2] && div_zero);
                        neg_rem <= neg1;
                        if (special)
                            result_o <= special_res;
                    end
                end
                MUL, DIV: begin
                    if (!kill_i) begin
                        acc <= acc_nxt;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31)
                            result_o <= final_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Directed bench for rv32m_muldiv_unit: latency, results, specials, kill, reset, back-to-back.
module tb_rv32m_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        kill = 1'b0;
    logic        stall, busy, done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    rv32m_muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
        .kill_i(kill), .stall_o(stall), .busy_o(busy), .done_o(done), .result_o(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one instruction, hold start_i until done_o; operands are scrambled after accept.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string tag);
        int   cyc;
        logic stall_ok;
        @(posedge clk); #1;
        start = 1'b1; op = o; rs1 = a; rs2 = b; kill = 1'b0;
        #1;
        stall_ok = stall;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #2;
            cyc++;
            if (cyc == 1) begin
                rs1 = $urandom;
                rs2 = $urandom;
            end
            if (!done && !stall) stall_ok = 1'b0;
        end
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " result"}, result, exp);
        check({tag, " stall before done"}, 32'(stall_ok), 32'd1);
        check({tag, " stall in done"}, 32'(stall), 32'd0);
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check({tag, " no redone"}, 32'(done), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    task automatic watch_no_done(input string tag);
        int n;
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        check({tag, " spurious done"}, 32'(n), 32'd0);
    endtask

    initial begin
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("stall forced in reset", 32'(stall), 32'd0);
        rst = 1'b0; start = 1'b0;
        #1;
        check("reset done", 32'(done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        check("reset result", result, 32'd0);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL 7*-3");       idle_check("MUL");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "MULH"); idle_check("MULH");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU"); idle_check("MULHU");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "MULHSU"); idle_check("MULHSU");
        run_op(3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33, "MUL shift"); idle_check("MUL shift");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "DIV -7/2");     idle_check("DIV");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "REM -7/2");     idle_check("REM");
        run_op(3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "DIV 7/-2");     idle_check("DIV2");
        run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "REM 7/-2");             idle_check("REM2");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "DIVU 100/7");                idle_check("DIVU");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 33, "REMU 100/7");                 idle_check("REMU");

        run_op(3'd4, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, "DIV by 0");              idle_check("DIV0");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1, "DIV neg by 0");  idle_check("DIVN0");
        run_op(3'd6, 32'd5, 32'd0, 32'd5, 1, "REM by 0");                      idle_check("REM0");
        run_op(3'd7, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1, "REMU by 0");     idle_check("REMU0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV ovf"); idle_check("DIVOVF");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "REM ovf");       idle_check("REMOVF");

        // kill during a divide
        @(posedge clk); #1;
        start = 1'b1; op = 3'd4; rs1 = 32'd100; rs2 = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        #1;
        check("kill cycle busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        kill = 1'b0; start = 1'b0;
        #1;
        check("kill idle stall", 32'(stall), 32'd0);
        check("kill idle busy", 32'(busy), 32'd0);
        check("kill idle done", 32'(done), 32'd0);
        watch_no_done("kill");
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 33, "MUL after kill"); idle_check("MUL after kill");

        // kill in the accept cycle
        @(posedge clk); #1;
        start = 1'b1; kill = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
        #1;
        check("kill accept stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        #1;
        check("kill accept busy", 32'(busy), 32'd0);
        check("kill accept done", 32'(done), 32'd0);

        // kill in DONE still shows done_o that cycle
        @(posedge clk); #1;
        start = 1'b1; op = 3'd5; rs1 = 32'd1; rs2 = 32'd0;
        @(posedge clk); #1;
        kill = 1'b1;
        #1;
        check("kill in done strobe", 32'(done), 32'd1);
        @(posedge clk); #1;
        kill = 1'b0; start = 1'b0;
        #1;
        check("after kill in done", 32'(done), 32'd0);

        // reset mid-multiply
        @(posedge clk); #1;
        start = 1'b1; op = 3'd0; rs1 = 32'd5; rs2 = 32'd6;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid reset stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        #1;
        check("post reset done", 32'(done), 32'd0);
        check("post reset busy", 32'(busy), 32'd0);
        check("post reset stall", 32'(stall), 32'd0);
        check("post reset result", result, 32'd0);
        watch_no_done("reset");

        // back-to-back: start held through DONE, next op accepted the cycle after
        run_op(3'd0, 32'd6, 32'd7, 32'd42, 33, "b2b MUL");
        run_op(3'd5, 32'd1000, 32'd10, 32'd100, 33, "b2b DIVU");
        idle_check("b2b");
        watch_no_done("b2b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
